// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer and its PWM generator.
// Holds default widths, the sequencer state encoding and the duty stepping helper.
// No ports; imported with `import pwm_pkg::*;`.
package pwm_pkg;

  localparam int DEF_DUTY_W     = 4;
  localparam int DEF_PWM_PERIOD = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    HOLD   = 2'd2,
    RETURN = 2'd3
  } fade_state_t;

  // Moves cur one LSB toward tgt; never overshoots and never wraps.
  // Takes plain unsigned integers so any duty width can use it via casts.
  function automatic int unsigned step_toward(input int unsigned cur,
                                              input int unsigned tgt);
    if (cur < tgt) begin
      return cur + 1;
    end else if (cur > tgt) begin
      return cur - 1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period counter: counts 0..PWM_PERIOD and wraps, flagging the terminal count.
// Ports: clk, reset (async, active-high), period_tick (high while count == PWM_PERIOD).
// Sharing this block and its reset with the PWM generator keeps both counters cycle-aligned.
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD
) (
  input  logic clk,
  input  logic reset,
  output logic period_tick
);

  localparam int CNT_W = $clog2(PWM_PERIOD + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign period_tick = (cnt_q == CNT_W'(PWM_PERIOD));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (period_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer: accepts a target duty by valid/ready and ramps duty_out one LSB per
// STEP_PERIODS PWM periods; duty only changes at a period boundary.
// Ports: clk, reset (async, active-high), cmd_valid/cmd_ready/cmd_target (command in),
//   duty_out (to generator), period_tick, busy, done (one-cycle completion pulse).
// Optional breathe mode (macro PWM_FADE_BREATHE_EN): hold at target, then ramp back to start.
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int STEP_PERIODS = 2,
  parameter int HOLD_PERIODS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  output logic [DUTY_W-1:0] duty_out,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  localparam int STEP_W = $clog2(STEP_PERIODS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

  fade_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] aim;
  logic [DUTY_W-1:0] duty_step;
  logic              step_due;

`ifdef PWM_FADE_BREATHE_EN
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  logic [DUTY_W-1:0] start_q, start_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // On the way back the ramp aims at the duty captured when the command was accepted.
  assign aim = (state_q == RETURN) ? start_q : tgt_q;
`else
  assign aim = tgt_q;
`endif

  pwm_period_tick #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_period (
    .clk         (clk),
    .reset       (reset),
    .period_tick (period_tick)
  );

  assign duty_step = DUTY_W'(step_toward(32'(duty_q), 32'(aim)));
  // The duty register updates on the terminal-count edge, so the new value
  // is first seen by the generator at period counter 0.
  assign step_due  = period_tick && (step_q == STEP_LAST);

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign duty_out  = duty_q;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    done_d  = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    start_d = start_q;
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d  = cmd_target;
          step_d = '0;
`ifdef PWM_FADE_BREATHE_EN
          start_d = duty_q;
`endif
          if (cmd_target == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (period_tick) begin
          step_d = step_q + 1'b1;
          if (step_due) begin
            step_d = '0;
            duty_d = duty_step;
            if (duty_step == tgt_q) begin
`ifdef PWM_FADE_BREATHE_EN
              state_d = HOLD;
              hold_d  = '0;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef PWM_FADE_BREATHE_EN
      HOLD: begin
        if (period_tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_d = RETURN;
            step_d  = '0;
          end
        end
      end
      RETURN: begin
        if (period_tick) begin
          step_d = step_q + 1'b1;
          if (step_due) begin
            step_d = '0;
            duty_d = duty_step;
            if (duty_step == start_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
      start_q <= '0;
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      done_q  <= done_d;
`ifdef PWM_FADE_BREATHE_EN
      start_q <= start_d;
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer with default parameters (16 clocks per PWM period).
// Expected values are hand-computed; expectations switch on PWM_FADE_BREATHE_EN.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic [3:0] duty_out;
  logic       period_tick;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  always #25 clk = ~clk;

  pwm_fade_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .duty_out    (duty_out),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [3:0] tgt;
    int         exp_k;      // falling edge (1 = first after accept) where done is seen
    int         exp_final;  // duty_out in the done cycle
    int         exp_peak;   // highest duty_out seen during the sequence
    bit         exp_busy;   // busy level expected before done
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench at the falling edge of a terminal-count cycle, so an accept on the
  // next rising edge starts the sequence exactly at period counter 0.
  task automatic align_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] tgt, input bit exp_busy, input int budget,
                         output int done_k, output int final_d, output int peak,
                         output int bad_busy, output int bad_glitch, output int bad_range,
                         output int post_bad);
    bit         ok;
    logic [3:0] prev_d;
    logic       prev_tick;
    int         lo, hi;
    align_tick(ok);
    check("align_tick", 32'(ok), 32'd1);
    lo = (duty_out < tgt) ? int'(duty_out) : int'(tgt);
    hi = (duty_out > tgt) ? int'(duty_out) : int'(tgt);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    prev_d     = duty_out;
    prev_tick  = period_tick;
    peak       = int'(duty_out);
    done_k     = -1;
    bad_busy   = 0;
    bad_glitch = 0;
    bad_range  = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      // A duty change is legal only right after a terminal-count cycle and by one LSB.
      if (duty_out !== prev_d) begin
        if (!prev_tick) bad_glitch++;
        if ((duty_out != prev_d + 4'd1) && (duty_out != prev_d - 4'd1)) bad_glitch++;
      end
      if ((int'(duty_out) < lo) || (int'(duty_out) > hi)) bad_range++;
      if (int'(duty_out) > peak) peak = int'(duty_out);
      prev_d    = duty_out;
      prev_tick = period_tick;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (busy !== exp_busy) bad_busy++;
    end
    final_d = int'(duty_out);
    @(negedge clk);
    post_bad = 0;
    if (done !== 1'b0) post_bad++;
    if (busy !== 1'b0) post_bad++;
    if (cmd_ready !== 1'b1) post_bad++;
  endtask

  initial begin
    bit         ok;
    int         done_k, final_d, peak, bad_busy, bad_glitch, bad_range, post_bad;
    int         bad_rdy, cnt;
    int         peak1;
    bit         seen;

    // ---------------- reset state ----------------
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    repeat (2) @(negedge clk);
    check("reset_duty", 32'(duty_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    // ---------------- reset mid-ramp at duty 6 ----------------
    align_tick(ok);
    cmd_valid  = 1'b1;
    cmd_target = 4'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (duty_out == 4'd6) begin
        seen = 1'b1;
        break;
      end
    end
    check("midramp_reached_6", 32'(seen), 32'd1);
    check("midramp_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midramp_rst_duty", 32'(duty_out), 32'd0);
    check("midramp_rst_busy", 32'(busy), 32'd0);
    check("midramp_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midramp_ready_after", 32'(cmd_ready), 32'd1);
    // The discarded target must not resume a ramp.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || duty_out !== 4'd0 || done !== 1'b0) cnt++;
    end
    check("midramp_stays_idle", 32'(cnt), 32'd0);

    // ---------------- command during a ramp is ignored, then accepted in done cycle ----
    align_tick(ok);
    cmd_valid  = 1'b1;
    cmd_target = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = 4'd9;
    bad_rdy = 0;
    seen    = 1'b0;
    peak1   = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (int'(duty_out) > peak1) peak1 = int'(duty_out);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (cmd_ready !== 1'b0) bad_rdy++;
    end
    check("busycmd_ready_low", 32'(bad_rdy), 32'd0);
    check("busycmd_first_done", 32'(seen), 32'd1);
    check("busycmd_first_peak", 32'(peak1), 32'd2);
`ifdef PWM_FADE_BREATHE_EN
    check("busycmd_first_final", 32'(duty_out), 32'd0);
`else
    check("busycmd_first_final", 32'(duty_out), 32'd2);
`endif
    check("busycmd_ready_in_done", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busycmd_accepted", 32'(busy), 32'd1);
    seen  = 1'b0;
    peak1 = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (int'(duty_out) > peak1) peak1 = int'(duty_out);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("busycmd_second_done", 32'(seen), 32'd1);
    check("busycmd_second_peak", 32'(peak1), 32'd9);
`ifdef PWM_FADE_BREATHE_EN
    check("busycmd_second_final", 32'(duty_out), 32'd0);
`else
    check("busycmd_second_final", 32'(duty_out), 32'd9);
`endif

    // ---------------- table of aligned commands from a fresh reset ----------------
    // Each step costs 2 periods * 16 clocks = 32 clocks; done is seen at edge 32*n+1.
`ifdef PWM_FADE_BREATHE_EN
    // Up n steps, 4 hold periods (64 clocks), down n steps.
    vecs.push_back('{tgt: 4'd8, exp_k: 577, exp_final: 0, exp_peak: 8, exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd0, exp_k: 1,   exp_final: 0, exp_peak: 0, exp_busy: 1'b0});
    vecs.push_back('{tgt: 4'd3, exp_k: 257, exp_final: 0, exp_peak: 3, exp_busy: 1'b1});
`else
    vecs.push_back('{tgt: 4'd4,  exp_k: 129, exp_final: 4,  exp_peak: 4,  exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd12, exp_k: 257, exp_final: 12, exp_peak: 12, exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd3,  exp_k: 289, exp_final: 3,  exp_peak: 12, exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd3,  exp_k: 1,   exp_final: 3,  exp_peak: 3,  exp_busy: 1'b0});
    vecs.push_back('{tgt: 4'd15, exp_k: 385, exp_final: 15, exp_peak: 15, exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd0,  exp_k: 481, exp_final: 0,  exp_peak: 15, exp_busy: 1'b1});
    vecs.push_back('{tgt: 4'd0,  exp_k: 1,   exp_final: 0,  exp_peak: 0,  exp_busy: 1'b0});
`endif

    do_reset();
    foreach (vecs[v]) begin
      run_cmd(vecs[v].tgt, vecs[v].exp_busy, 700,
              done_k, final_d, peak, bad_busy, bad_glitch, bad_range, post_bad);
      check($sformatf("vec%0d_done_edge", v), 32'(done_k), 32'(vecs[v].exp_k));
      check($sformatf("vec%0d_final_duty", v), 32'(final_d), 32'(vecs[v].exp_final));
      check($sformatf("vec%0d_peak_duty", v), 32'(peak), 32'(vecs[v].exp_peak));
      check($sformatf("vec%0d_busy_errs", v), 32'(bad_busy), 32'd0);
      check($sformatf("vec%0d_step_errs", v), 32'(bad_glitch), 32'd0);
      check($sformatf("vec%0d_range_errs", v), 32'(bad_range), 32'd0);
      check($sformatf("vec%0d_after_done_errs", v), 32'(post_bad), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
